sram_1p_mask_init: RTL and testbench

- Parametrised single-port synchronous SRAM behavioural model. Successor to the fixed 128x8 single-port macro model.
- Adds per-segment write mask, selectable 1- or 2-cycle read latency, and a post-reset hardware clear sequence.
- Adds defined output-hold behaviour.
- Sits under cache data/tag array wrappers in simulation and FPGA builds.

---
 rtl/sram_1p_mask_init.sv | 116 +++++++++++
 tb/tb_sram_1p_mask_init.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sram_1p_mask_init.sv
// sram_1p_mask_init: single-port SRAM model with segment write mask, 1/2-cycle read latency and post-reset clear.
// Optional macro SRAM_RAND_Q_EN: Q carries pseudo-random data on RUN cycles where no read result lands.
module sram_1p_mask_init #(
    parameter int Bits = 64,
    parameter int Word_Depth = 128,
    parameter int Add_Width = 7,
    parameter int Mask_Gran = 8,
    parameter int Read_Latency = 1,
    parameter logic [Bits-1:0] Init_Value = '0
) (
    input  logic                      CLK,
    input  logic                      RSTB,
    input  logic                      CEB,
    input  logic                      WEB,
    input  logic [Bits/Mask_Gran-1:0] BWEB,
    input  logic [Add_Width-1:0]      A,
    input  logic [Bits-1:0]           D,
    output logic [Bits-1:0]           Q,
    output logic                      READY
);
    localparam int NSeg = Bits / Mask_Gran;

    typedef enum logic {INIT, RUN} state_e;

    state_e                 state_q, state_d;
    logic [Add_Width-1:0]   cnt_q, cnt_d;
    logic [Bits-1:0]        mem [Word_Depth];
    logic [Bits-1:0]        rd_data, wr_mask, land_data, q_q;
    logic                   run, rd_req, wr_req, in_rng, land;

    if (Bits % Mask_Gran != 0) begin : g_bad_gran
        $error("sram_1p_mask_init: Bits must be a multiple of Mask_Gran");
    end
    if (Word_Depth > (1 << Add_Width)) begin : g_bad_depth
        $error("sram_1p_mask_init: Word_Depth exceeds 2**Add_Width");
    end

    assign run    = state_q == RUN;
    assign rd_req = run && !CEB && WEB;
    assign wr_req = run && !CEB && !WEB;
    assign in_rng = int'(A) < Word_Depth;
    assign rd_data = in_rng ? mem[A] : '0;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < NSeg; i++) wr_mask[i*Mask_Gran +: Mask_Gran] = {Mask_Gran{~BWEB[i]}};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == Add_Width'(Word_Depth - 1)) state_d = RUN;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The array is never reset; RSTB only gates the clear writes so a held reset leaves contents alone.
    always_ff @(posedge CLK) begin
        if (RSTB && state_q == INIT) mem[cnt_q] <= Init_Value;
        else if (wr_req && in_rng) mem[A] <= (mem[A] & ~wr_mask) | (D & wr_mask);
    end

    if (Read_Latency == 1) begin : g_lat1
        assign land      = rd_req;
        assign land_data = rd_data;
    end else if (Read_Latency == 2) begin : g_lat2
        logic [Bits-1:0] s1_q;
        logic            v1_q;
        always_ff @(posedge CLK or negedge RSTB) begin
            if (!RSTB) begin
                s1_q <= '0;
                v1_q <= 1'b0;
            end else begin
                v1_q <= rd_req;
                if (rd_req) s1_q <= rd_data;
            end
        end
        assign land      = v1_q;
        assign land_data = s1_q;
    end else begin : g_bad_lat
        $error("sram_1p_mask_init: Read_Latency must be 1 or 2");
        assign land      = 1'b0;
        assign land_data = '0;
    end

`ifdef SRAM_RAND_Q_EN
    localparam int NWords = (Bits + 31) / 32;
    function automatic logic [Bits-1:0] rand_word();
        logic [NWords*32-1:0] w;
        for (int i = 0; i < NWords; i++) w[i*32 +: 32] = $random;
        return w[Bits-1:0];
    endfunction
`endif

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) q_q <= '0;
        else if (land) q_q <= land_data;
`ifdef SRAM_RAND_Q_EN
        else if (run) q_q <= rand_word();
`endif
    end

    assign Q     = q_q;
    assign READY = run;
endmodule

// File: tb/tb_sram_1p_mask_init.sv
// tb_sram_1p_mask_init: randomized check of two SRAM configurations (latency 1 depth 100, latency 2 depth 16) against an array model.
module tb_sram_1p_mask_init;
    localparam int DA = 100;
    localparam int DB = 16;
    localparam logic [63:0] IV = 64'hA5A5;

    logic        clk = 1'b0, rstb = 1'b0, ceb = 1'b1, web = 1'b1;
    logic [7:0]  bweb = 8'hFF;
    logic [6:0]  a = '0;
    logic [63:0] d = '0;
    logic [63:0] q_a, q_b;
    logic        rdy_a, rdy_b;

    always #5 clk = ~clk;

    sram_1p_mask_init #(.Bits(64), .Word_Depth(DA), .Add_Width(7), .Mask_Gran(8),
                        .Read_Latency(1), .Init_Value(IV)) u_a (
        .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d), .Q(q_a), .READY(rdy_a));

    sram_1p_mask_init #(.Bits(64), .Word_Depth(DB), .Add_Width(7), .Mask_Gran(8),
                        .Read_Latency(2), .Init_Value(IV)) u_b (
        .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d), .Q(q_b), .READY(rdy_b));

    int          total = 0, bad = 0;
    logic [63:0] ma [DA];
    logic [63:0] mb [DB];
    int          ka = 0, kb = 0;
    logic [63:0] eqa = '0, eqb = '0, pd_b = '0;
    logic        pv_b = 1'b0;
    bit          in_rst = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (!m[i]) old[i*8 +: 8] = nw[i*8 +: 8];
        return old;
    endfunction

    // Applies one rising edge to the model using the inputs that were sampled on it.
    task automatic model_edge();
        logic ra, rb;
        logic [63:0] da, db;
        ra = 1'b0; rb = 1'b0; da = '0; db = '0;
        if (in_rst) return;
        if (ka < DA) begin
            ma[ka] = IV;
            ka++;
        end else if (!ceb) begin
            if (!web) begin
                if (a < DA) ma[a] = merge(ma[a], d, bweb);
            end else begin
                ra = 1'b1;
                da = (a < DA) ? ma[a] : '0;
            end
        end
        if (kb < DB) begin
            mb[kb] = IV;
            kb++;
        end else if (!ceb) begin
            if (!web) begin
                if (a < DB) mb[a] = merge(mb[a], d, bweb);
            end else begin
                rb = 1'b1;
                db = (a < DB) ? mb[a] : '0;
            end
        end
        if (ra) eqa = da;
        if (pv_b) eqb = pd_b;
        pv_b = rb;
        pd_b = db;
    endtask

    task automatic check_all();
        chk("q_a", q_a, eqa);
        chk("q_b", q_b, eqb);
        chk("ready_a", 64'(rdy_a), 64'(ka >= DA));
        chk("ready_b", 64'(rdy_b), 64'(kb >= DB));
    endtask

    task automatic cyc(input logic c, input logic w, input logic [7:0] m, input logic [6:0] ad, input logic [63:0] dd);
        ceb = c; web = w; bweb = m; a = ad; d = dd;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 8'hFF, 7'($urandom), 64'({$urandom, $urandom}));
    endtask

    // Assert reset between edges, confirm outputs drop at once, release mid-cycle.
    task automatic hit_reset();
        #2;
        rstb = 1'b0;
        in_rst = 1'b1;
        ka = 0; kb = 0; eqa = '0; eqb = '0; pv_b = 1'b0; pd_b = '0;
        #1;
        chk("rst_q_a", q_a, 64'h0);
        chk("rst_q_b", q_b, 64'h0);
        chk("rst_rdy_a", 64'(rdy_a), 64'h0);
        chk("rst_rdy_b", 64'(rdy_b), 64'h0);
        repeat (2) @(posedge clk);
        #2;
        rstb = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DA; i++) ma[i] = 'x;
        for (int i = 0; i < DB; i++) mb[i] = 'x;
        #1;
        chk("por_q_a", q_a, 64'h0);
        chk("por_rdy_b", 64'(rdy_b), 64'h0);
        repeat (2) @(posedge clk);
        #2;
        rstb = 1'b1;
        in_rst = 1'b0;
        // Reads requested from the very first cycle must be ignored during the clear.
        for (int i = 0; i < 110; i++) cyc(1'b0, 1'b1, 8'($urandom), 7'(i), 64'({$urandom, $urandom}));
        for (int i = 0; i < DA; i++) cyc(1'b0, 1'b1, 8'hFF, 7'(i), '0);
        idle(2);
        chk("clear_hold_a", q_a, IV);
        // Masked write onto a zeroed word.
        cyc(1'b0, 1'b0, 8'h00, 7'd3, 64'h0);
        cyc(1'b0, 1'b0, 8'hF0, 7'd3, 64'h1122334455667788);
        cyc(1'b0, 1'b1, 8'hFF, 7'd3, '0);
        chk("mask_a", q_a, 64'h0000000055667788);
        idle(1);
        chk("mask_b", q_b, 64'h0000000055667788);
        // Back-to-back reads through both pipelines.
        cyc(1'b0, 1'b0, 8'h00, 7'd1, 64'h11);
        cyc(1'b0, 1'b0, 8'h00, 7'd2, 64'h22);
        cyc(1'b0, 1'b0, 8'h00, 7'd3, 64'h33);
        cyc(1'b0, 1'b1, 8'hFF, 7'd1, '0);
        cyc(1'b0, 1'b1, 8'hFF, 7'd2, '0);
        chk("lat2_first", q_b, 64'h11);
        cyc(1'b0, 1'b1, 8'hFF, 7'd3, '0);
        chk("lat2_second", q_b, 64'h22);
        idle(1);
        chk("lat2_third", q_b, 64'h33);
        idle(3);
        chk("lat2_hold", q_b, 64'h33);
        // Out-of-range write dropped, read returns zero.
        cyc(1'b0, 1'b0, 8'h00, 7'd120, 64'hFF);
        cyc(1'b0, 1'b1, 8'hFF, 7'd120, '0);
        chk("oor_read_a", q_a, 64'h0);
        cyc(1'b0, 1'b1, 8'hFF, 7'd99, '0);
        chk("oor_neighbor_a", q_a, IV);
        // Randomized traffic, biased toward the shallow DUT's range.
        for (int i = 0; i < 800; i++)
            cyc(1'($urandom_range(0, 4) == 0), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 19)),
                64'({$urandom, $urandom}));
        // Reset mid-operation rewrites the array.
        cyc(1'b0, 1'b0, 8'h00, 7'd5, 64'hDEAD);
        hit_reset();
        for (int i = 0; i < DA + 2; i++) cyc(1'b0, 1'b1, 8'hFF, 7'd5, '0);
        chk("post_rst_a", q_a, IV);
        chk("post_rst_b", q_b, IV);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
